spi_param_reg_bank: RTL and testbench

//  Parametrised, single-clock successor to the SPI peripheral register block: an N-register, W-bit SPI slave.

---
 rtl/spi_param_reg_bank_if.sv | 19 +
 rtl/spi_param_reg_bank.sv | 197 +++++++++++++++++++
 tb/tb_spi_param_reg_bank.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_param_reg_bank_if.sv
// SPI pins between a host and the register bank.
// The host drives sclk and serial_in; the bank drives serial_out.
interface spi_param_reg_bank_if;
    logic sclk;
    logic serial_in;
    logic serial_out;

    modport master (
        output sclk,
        output serial_in,
        input  serial_out
    );

    modport slave (
        input  sclk,
        input  serial_in,
        output serial_out
    );
endinterface

// File: rtl/spi_param_reg_bank.sv
// Oversampled SPI slave register bank: address then auto-incrementing
// full-duplex words, frame closed by an sclk idle timeout.
module spi_param_reg_bank #(
    parameter int                  NUM_REGS     = 8,
    parameter int                  DATA_W       = 8,
    parameter int                  ADDR_W       = 8,
    parameter logic [NUM_REGS-1:0] WR_MASK      = 8'hFF,
    parameter int                  IDLE_TIMEOUT = 64,
    parameter int                  SYNC_STAGES  = 2
) (
    input  logic                       iclk,
    input  logic                       rst,
    spi_param_reg_bank_if.slave        spi,
    input  logic [NUM_REGS*DATA_W-1:0] ro_data,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_active
);

    localparam int MAX_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W  = $clog2(MAX_W + 1);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] si_sync;
    logic                   sclk_d;
    logic                   sclk_s;
    logic                   bit_s;
    logic                   rise;
    logic                   fall;

    logic [1:0]        state, state_n;
    logic [CNT_W-1:0]  bit_cnt, bit_n;
    logic [IDLE_W-1:0] idle_cnt, idle_n;
    logic [ADDR_W-1:0] addr_sh, ash_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] rx_sh, rx_n;
    logic [DATA_W-1:0] tx_sh, tx_n;
    logic              so_q;

    logic [ADDR_W-1:0] addr_full;
    logic [DATA_W-1:0] rx_full;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_val;
    logic              wr_ok;
    logic              wr_en;
    logic [DATA_W-1:0] wr_d;

    logic [DATA_W-1:0] regs [NUM_REGS];

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign bit_s     = si_sync[SYNC_STAGES-1];
    assign rise      = sclk_s & ~sclk_d;
    assign fall      = ~sclk_s & sclk_d;
    assign addr_full = {bit_s, addr_sh[ADDR_W-1:1]};
    assign rx_full   = {bit_s, rx_sh[DATA_W-1:1]};
    assign rd_addr   = (state == DATA) ? addr_q + 1'b1 : addr_full;

    assign spi.serial_out = so_q;
    assign frame_active   = (state != IDLE);

    // Read-only slots show 0; writable slots show the stored value.
    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_out
            assign regs_out[g*DATA_W +: DATA_W] =
                WR_MASK[g] ? regs[g] : '0;
        end
    endgenerate

    // Read mux: out of range reads 0, RO slots come from ro_data.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(rd_addr) == i) begin
                rd_val = WR_MASK[i] ? regs[i]
                                    : ro_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A write lands only on an in-range, writable register.
    always_comb begin
        wr_ok = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(addr_q) == i && WR_MASK[i]) wr_ok = 1'b1;
        end
    end

    // Frame FSM next-state, shifters and idle timeout.
    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        idle_n  = idle_cnt;
        ash_n   = addr_sh;
        addr_n  = addr_q;
        rx_n    = rx_sh;
        tx_n    = tx_sh;
        wr_en   = 1'b0;
        wr_d    = rx_full;
        unique case (state)
            IDLE: begin
                idle_n = '0;
                if (rise) begin
                    ash_n   = addr_full;
                    bit_n   = CNT_W'(1);
                    tx_n    = '0;
                    state_n = ADDR;
                end
            end
            ADDR: begin
                if (rise) begin
                    ash_n = addr_full;
                    if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
                        addr_n  = addr_full;
                        bit_n   = '0;
                        tx_n    = rd_val;
                        state_n = DATA;
                    end else begin
                        bit_n = bit_cnt + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (rise) begin
                    rx_n = rx_full;
                    tx_n = tx_sh >> 1;
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        wr_en  = wr_ok;
                        addr_n = addr_q + 1'b1;
                        tx_n   = rd_val;
                        bit_n  = '0;
                    end else begin
                        bit_n = bit_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // An edge on the timeout cycle keeps the frame alive.
        if (state != IDLE) begin
            if (rise || fall) begin
                idle_n = '0;
            end else if (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                idle_n  = '0;
                bit_n   = '0;
                state_n = IDLE;
            end else begin
                idle_n = idle_cnt + IDLE_W'(1);
            end
        end
    end

    // State, synchronizers, registers and outputs.
    always_ff @(posedge iclk) begin
        if (rst) begin
            sclk_sync <= '0;
            si_sync   <= '0;
            sclk_d    <= 1'b0;
            state     <= IDLE;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            addr_sh   <= '0;
            addr_q    <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            so_q      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            si_sync   <= {si_sync[SYNC_STAGES-2:0], spi.serial_in};
            sclk_d    <= sclk_s;
            state     <= state_n;
            bit_cnt   <= bit_n;
            idle_cnt  <= idle_n;
            addr_sh   <= ash_n;
            addr_q    <= addr_n;
            rx_sh     <= rx_n;
            tx_sh     <= tx_n;
            so_q      <= (state_n != IDLE) & tx_n[0];
            wr_strobe <= wr_en;
            if (wr_en) wr_addr <= addr_q;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && 32'(addr_q) == i && WR_MASK[i])
                    regs[i] <= wr_d;
            end
        end
    end

endmodule

// File: tb/tb_spi_param_reg_bank.sv
// Directed bench for the SPI register bank: two instances share the
// SPI pins, one fully writable, one with register 7 read-only.
module tb_spi_param_reg_bank;

    logic        iclk;
    logic        rst;
    logic [63:0] ro_a, ro_b;
    logic [63:0] regs_a, regs_b;
    logic        stb_a, stb_b;
    logic [7:0]  wa_a, wa_b;
    logic        act_a, act_b;

    int total = 0;
    int bad   = 0;
    int scnt_a = 0;
    int scnt_b = 0;

    spi_param_reg_bank_if bus_a ();
    spi_param_reg_bank_if bus_b ();

    assign bus_b.sclk      = bus_a.sclk;
    assign bus_b.serial_in = bus_a.serial_in;

    spi_param_reg_bank dut_a (
        .iclk(iclk), .rst(rst), .spi(bus_a.slave),
        .ro_data(ro_a), .regs_out(regs_a),
        .wr_strobe(stb_a), .wr_addr(wa_a),
        .frame_active(act_a)
    );

    spi_param_reg_bank #(.WR_MASK(8'h7F)) dut_b (
        .iclk(iclk), .rst(rst), .spi(bus_b.slave),
        .ro_data(ro_b), .regs_out(regs_b),
        .wr_strobe(stb_b), .wr_addr(wa_b),
        .frame_active(act_b)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    always @(negedge iclk) begin
        if (!rst) begin
            if (stb_a) scnt_a = scnt_a + 1;
            if (stb_b) scnt_b = scnt_b + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic do_reset;
        bus_a.sclk      = 1'b0;
        bus_a.serial_in = 1'b0;
        @(negedge iclk);
        rst = 1'b1;
        repeat (2) @(negedge iclk);
        rst = 1'b0;
        scnt_a = 0;
        scnt_b = 0;
    endtask

    // LSB-first host; serial_out is sampled just before each rise.
    task automatic send_bits(input logic [7:0] val, input int n,
                             output logic [7:0] ga,
                             output logic [7:0] gb);
        ga = '0;
        gb = '0;
        for (int i = 0; i < n; i++) begin
            bus_a.serial_in = val[i];
            repeat (4) @(negedge iclk);
            ga[i] = bus_a.serial_out;
            gb[i] = bus_b.serial_out;
            bus_a.sclk = 1'b1;
            repeat (4) @(negedge iclk);
            bus_a.sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] addr, input int nw,
                              input logic [23:0] words,
                              output logic [23:0] ga,
                              output logic [23:0] gb);
        logic [7:0] xa, xb;
        ga = '0;
        gb = '0;
        send_bits(addr, 8, xa, xb);
        for (int j = 0; j < nw; j++) begin
            send_bits(words[8*j +: 8], 8, xa, xb);
            ga[8*j +: 8] = xa;
            gb[8*j +: 8] = xb;
        end
    endtask

    task automatic end_frame;
        repeat (80) @(negedge iclk);
    endtask

    task automatic test_reset;
        do_reset();
        chk("rst_active", {63'd0, act_a}, 64'd0);
        chk("rst_regs", regs_a, 64'd0);
        chk("rst_sout", {63'd0, bus_a.serial_out}, 64'd0);
        chk("rst_strobe", {63'd0, stb_a}, 64'd0);
        chk("rst_waddr", {56'd0, wa_a}, 64'd0);
    endtask

    task automatic test_single_write;
        logic [23:0] ga, gb;
        do_reset();
        send_frame(8'h02, 1, 24'h0000A5, ga, gb);
        chk("w1_active", {63'd0, act_a}, 64'd1);
        end_frame();
        chk("w1_regs", regs_a, 64'h0000_0000_00A5_0000);
        chk("w1_strobes", 64'(scnt_a), 64'd1);
        chk("w1_waddr", {56'd0, wa_a}, 64'd2);
        chk("w1_idle", {63'd0, act_a}, 64'd0);
    endtask

    task automatic test_stream;
        logic [23:0] ga, gb;
        do_reset();
        send_frame(8'h06, 2, 24'h002211, ga, gb);
        end_frame();
        chk("st_preload", regs_a, 64'h2211_0000_0000_0000);
        scnt_a = 0;
        send_frame(8'h06, 3, 24'h554433, ga, gb);
        end_frame();
        chk("st_sout", {40'd0, ga}, 64'h0000_0000_0000_2211);
        chk("st_regs", regs_a, 64'h4433_0000_0000_0000);
        chk("st_strobes", 64'(scnt_a), 64'd2);
        chk("st_waddr", {56'd0, wa_a}, 64'd7);
    endtask

    task automatic test_read_only;
        logic [23:0] ga, gb;
        do_reset();
        send_frame(8'h07, 1, 24'h0000FF, ga, gb);
        end_frame();
        chk("ro_sout", {56'd0, gb[7:0]}, 64'h5A);
        chk("ro_strobes", 64'(scnt_b), 64'd0);
        chk("ro_regs", {56'd0, regs_b[63:56]}, 64'd0);
        chk("ro_rw_ok", {56'd0, regs_a[63:56]}, 64'hFF);
    endtask

    task automatic test_timeout;
        logic [7:0] xa, xb;
        logic [23:0] ga, gb;
        do_reset();
        send_bits(8'h01, 8, xa, xb);
        send_bits(8'h1F, 5, xa, xb);
        repeat (50) @(negedge iclk);
        chk("to_still_act", {63'd0, act_a}, 64'd1);
        repeat (30) @(negedge iclk);
        chk("to_idle", {63'd0, act_a}, 64'd0);
        chk("to_reg1", {56'd0, regs_a[15:8]}, 64'd0);
        chk("to_strobes", 64'(scnt_a), 64'd0);
        send_frame(8'h01, 1, 24'h00000F, ga, gb);
        end_frame();
        chk("to_new_reg1", regs_a, 64'h0000_0000_0000_0F00);
    endtask

    task automatic test_wrap;
        logic [23:0] ga, gb;
        do_reset();
        send_frame(8'hFF, 2, 24'h003412, ga, gb);
        end_frame();
        chk("wr_regs", regs_a, 64'h0000_0000_0000_0034);
        chk("wr_strobes", 64'(scnt_a), 64'd1);
        chk("wr_waddr", {56'd0, wa_a}, 64'd0);
    endtask

    task automatic test_back_to_back;
        logic [7:0] xa, xb;
        logic [23:0] ga, gb;
        do_reset();
        send_frame(8'h03, 1, 24'h000077, ga, gb);
        end_frame();
        send_bits(8'h03, 8, xa, xb);
        send_bits(8'h00, 2, xa, xb);
        chk("mr_pre_sout", {63'd0, bus_a.serial_out}, 64'd1);
        chk("mr_pre_act", {63'd0, act_a}, 64'd1);
        rst = 1'b1;
        @(posedge iclk);
        #1;
        chk("mr_act", {63'd0, act_a}, 64'd0);
        chk("mr_regs", regs_a, 64'd0);
        chk("mr_sout", {63'd0, bus_a.serial_out}, 64'd0);
        chk("mr_strobe", {63'd0, stb_a}, 64'd0);
        @(negedge iclk);
        rst = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus_a.sclk      = 1'b0;
        bus_a.serial_in = 1'b0;
        ro_a            = '0;
        ro_b            = 64'h5A00_0000_0000_0000;
        test_reset();
        test_single_write();
        test_stream();
        test_read_only();
        test_timeout();
        test_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
